magic_nor_executor: RTL

- Sequential executor for NOR/NOT-mapped gate netlists, emulating in-memory MAGIC evaluation on a bit-cell array.
- A host writes a micro-op program (nor2/inv1 ops over cell indices) and starts the block with a primary-input vector.
- The block runs ops in order, each as an INIT (dst cell set to 1) then an EVAL (dst = NOR of sources), and returns one selected output cell.
- It is the consumer/executor side of the NOR netlists our mapping flow produces.

---
 rtl/magic_nor_pkg.sv | 47 ++++
 rtl/magic_nor_executor_if.sv | 35 +++
 rtl/magic_cell_array.sv | 45 ++++
 rtl/magic_nor_executor.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/magic_nor_pkg.sv
// Shared types for the MAGIC NOR executor.
//   opcode_e   : micro-op opcodes
//   state_e    : executor FSM states
//   micro_op_t : packed micro-op {opc, dst, srca, srcb} at the default cell-address width
//   op_width() : micro-op word width for a given cell-address width
//   addr_valid(): range check used for cell and program addresses
package magic_nor_pkg;

    localparam int unsigned NUM_CELLS_DEF  = 32;
    localparam int unsigned NUM_INPUTS_DEF = 8;
    localparam int unsigned PROG_DEPTH_DEF = 32;
    localparam int unsigned CA_W_DEF       = $clog2(NUM_CELLS_DEF);
    localparam int unsigned PA_W_DEF       = $clog2(PROG_DEPTH_DEF);

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_NOR2 = 2'b01,
        OP_INV1 = 2'b10,
        OP_END  = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        INIT,
        EVAL,
        FIN,
        DONE
    } state_e;

    typedef struct packed {
        opcode_e             opc;
        logic [CA_W_DEF-1:0] dst;
        logic [CA_W_DEF-1:0] srca;
        logic [CA_W_DEF-1:0] srcb;
    } micro_op_t;

    function automatic int unsigned op_width(input int unsigned ca_w);
        return 2 + 3 * ca_w;
    endfunction

    function automatic logic addr_valid(input int unsigned addr, input int unsigned limit);
        return addr < limit;
    endfunction

endpackage

// File: rtl/magic_nor_executor_if.sv
// Host-side bus of the MAGIC NOR executor.
//   master : host (program writes, start/in_vec/num_ops/out_sel; sees busy/done/result/err)
//   slave  : executor
interface magic_nor_executor_if #(
    parameter int unsigned NUM_INPUTS = 8,
    parameter int unsigned CA_W       = 5,
    parameter int unsigned PA_W       = 5
);
    import magic_nor_pkg::*;

    localparam int unsigned OP_W = op_width(CA_W);

    logic                  prog_we;
    logic [PA_W-1:0]       prog_addr;
    logic [OP_W-1:0]       prog_data;
    logic                  start;
    logic [NUM_INPUTS-1:0] in_vec;
    logic [PA_W:0]         num_ops;
    logic [CA_W-1:0]       out_sel;
    logic                  busy;
    logic                  done;
    logic                  result;
    logic                  err;

    modport master (
        output prog_we, prog_addr, prog_data, start, in_vec, num_ops, out_sel,
        input  busy, done, result, err
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, start, in_vec, num_ops, out_sel,
        output busy, done, result, err
    );

endinterface

// File: rtl/magic_cell_array.sv
// Bit-cell array emulating a MAGIC crossbar row.
//   load/load_vec : bulk load primary inputs into the low cells, clear the rest
//   init          : cells[dst] <= 1
//   eval/inv      : cells[dst] <= NOR(cells[rd_a], cells[rd_b]) (rd_b ignored when inv)
//   rd_a/rd_b     : combinational read ports, values on val_a/val_b
module magic_cell_array
    import magic_nor_pkg::*;
#(
    parameter int unsigned NUM_CELLS  = 32,
    parameter int unsigned NUM_INPUTS = 8,
    parameter int unsigned CA_W       = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [NUM_INPUTS-1:0] load_vec,
    input  logic                  init,
    input  logic                  eval,
    input  logic                  inv,
    input  logic [CA_W-1:0]       dst,
    input  logic [CA_W-1:0]       rd_a,
    input  logic [CA_W-1:0]       rd_b,
    output logic                  val_a,
    output logic                  val_b
);

    logic [NUM_CELLS-1:0] cells;

    assign val_a = addr_valid(32'(rd_a), NUM_CELLS) ? cells[rd_a] : 1'b0;
    assign val_b = addr_valid(32'(rd_b), NUM_CELLS) ? cells[rd_b] : 1'b0;

    // EVAL reads after INIT, so a source aliasing dst sees 1 and forces a 0 result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cells <= '0;
        end else if (load) begin
            cells <= {{(NUM_CELLS - NUM_INPUTS){1'b0}}, load_vec};
        end else if (init) begin
            cells[dst] <= 1'b1;
        end else if (eval) begin
            cells[dst] <= ~(val_a | (~inv & val_b));
        end
    end

endmodule

// File: rtl/magic_nor_executor.sv
// Sequential executor for NOR/NOT micro-op programs over a MAGIC bit-cell array.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : host interface (program writes, start, status and result)
module magic_nor_executor
    import magic_nor_pkg::*;
#(
    parameter int unsigned NUM_CELLS  = NUM_CELLS_DEF,
    parameter int unsigned NUM_INPUTS = NUM_INPUTS_DEF,
    parameter int unsigned PROG_DEPTH = PROG_DEPTH_DEF,
    parameter int unsigned CA_W       = $clog2(NUM_CELLS),
    parameter int unsigned PA_W       = $clog2(PROG_DEPTH)
) (
    input logic                 clk,
    input logic                 rst,
    magic_nor_executor_if.slave bus
);

    localparam int unsigned OP_W = op_width(CA_W);

    logic [OP_W-1:0]       prog_mem [PROG_DEPTH];

    state_e                state;
    logic [PA_W-1:0]       pc;
    logic [PA_W:0]         num_ops_q;
    logic [CA_W-1:0]       out_sel_q;
    logic [NUM_INPUTS-1:0] in_vec_q;
    opcode_e               opc_q;
    logic [CA_W-1:0]       dst_q;
    logic [CA_W-1:0]       srca_q;
    logic [CA_W-1:0]       srcb_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  result_q;
    logic                  err_q;

    logic                  host_ok;
    logic [OP_W-1:0]       fetch_word;
    opcode_e               fetch_opc;
    logic [CA_W-1:0]       fetch_dst;
    logic [CA_W-1:0]       fetch_srca;
    logic [CA_W-1:0]       fetch_srcb;
    logic                  fetch_illegal;
    logic [PA_W:0]         pc_inc;
    logic                  last_op;
    logic [CA_W-1:0]       rd_a;
    logic                  val_a;
    logic                  val_b;

    assign host_ok = (state == IDLE) || (state == DONE);

    // Program memory is intentionally not reset.
    always_ff @(posedge clk) begin
        if (bus.prog_we && host_ok && addr_valid(32'(bus.prog_addr), PROG_DEPTH)) begin
            prog_mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    assign fetch_word = prog_mem[pc];
    assign fetch_opc  = opcode_e'(fetch_word[OP_W-1 -: 2]);
    assign fetch_dst  = fetch_word[3*CA_W-1 -: CA_W];
    assign fetch_srca = fetch_word[2*CA_W-1 -: CA_W];
    assign fetch_srcb = fetch_word[CA_W-1:0];

    assign fetch_illegal = ((fetch_opc == OP_NOR2) || (fetch_opc == OP_INV1)) &&
                           ((32'(fetch_dst) < NUM_INPUTS) ||
                            !addr_valid(32'(fetch_dst), NUM_CELLS) ||
                            !addr_valid(32'(fetch_srca), NUM_CELLS) ||
                            ((fetch_opc == OP_NOR2) && !addr_valid(32'(fetch_srcb), NUM_CELLS)));

    // Run ends when the op count is reached or pc would wrap past the last entry.
    assign pc_inc  = {1'b0, pc} + (PA_W + 1)'(1);
    assign last_op = (pc_inc == num_ops_q) || (pc == PA_W'(PROG_DEPTH - 1));

    // Read port A doubles as the result read in FIN.
    assign rd_a = (state == FIN) ? out_sel_q : srca_q;

    magic_cell_array #(
        .NUM_CELLS  (NUM_CELLS),
        .NUM_INPUTS (NUM_INPUTS),
        .CA_W       (CA_W)
    ) u_cells (
        .clk      (clk),
        .rst      (rst),
        .load     (state == LOAD),
        .load_vec (in_vec_q),
        .init     (state == INIT),
        .eval     (state == EVAL),
        .inv      (opc_q == OP_INV1),
        .dst      (dst_q),
        .rd_a     (rd_a),
        .rd_b     (srcb_q),
        .val_a    (val_a),
        .val_b    (val_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= '0;
            num_ops_q <= '0;
            out_sel_q <= '0;
            in_vec_q  <= '0;
            opc_q     <= OP_NOP;
            dst_q     <= '0;
            srca_q    <= '0;
            srcb_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        in_vec_q  <= bus.in_vec;
                        num_ops_q <= bus.num_ops;
                        out_sel_q <= bus.out_sel;
                        err_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    pc    <= '0;
                    state <= (num_ops_q == '0) ? FIN : FETCH;
                end
                FETCH: begin
                    opc_q  <= fetch_opc;
                    dst_q  <= fetch_dst;
                    srca_q <= fetch_srca;
                    srcb_q <= fetch_srcb;
                    if (fetch_opc == OP_END) begin
                        state <= FIN;
                    end else if (fetch_opc == OP_NOP) begin
                        pc    <= pc_inc[PA_W-1:0];
                        state <= last_op ? FIN : FETCH;
                    end else if (fetch_illegal) begin
                        err_q <= 1'b1;
                        state <= FIN;
                    end else begin
                        state <= INIT;
                    end
                end
                INIT: begin
                    state <= EVAL;
                end
                EVAL: begin
                    pc    <= pc_inc[PA_W-1:0];
                    state <= last_op ? FIN : FETCH;
                end
                FIN: begin
                    result_q <= val_a;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.err    = err_q;

endmodule
